// File: rtl/phy_defs.sv
`default_nettype none
// ============================================================================
//  Module      : phy_defs (package)
//  Description : Shared PHY lane definitions used by the transmit-side
//                serializer and the receive-side deserializer. It holds the
//                comma/idle symbol, the receive FSM state encoding and a
//                saturating counter helper.
//  Revision    : 1.0  initial release
// ============================================================================
package phy_defs;

   // Alignment / idle symbol. The transmitter inserts it when it has no data.
   localparam logic [7:0] COMMA = 8'hBC;

   // Serial bits per symbol.
   localparam int unsigned BYTE_BITS = 8;

   // Receive-side alignment state machine encoding.
   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      ALIGN  = 2'd1,
      ACTIVE = 2'd2
   } rx_state_t;

   // 4-bit increment that sticks at 15 instead of wrapping to 0.
   function automatic logic [3:0] sat_inc4(input logic [3:0] value);
      return (value == 4'hF) ? value : value + 4'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/comma_detect.sv
`default_nettype none
// ============================================================================
//  Module      : comma_detect
//  Description : Combinational comma recogniser for the receive lane. It
//                compares the shift-register image against the comma symbol
//                and flags the symbol-boundary edge (bit counter at zero).
//  Ports       : i_sr         - registered 8-bit shift register image
//                i_bit_cnt    - edges since the last symbol boundary
//                o_is_comma   - i_sr equals COMMA
//                o_boundary   - current edge is a symbol boundary
//  Revision    : 1.0  initial release
// ============================================================================
module comma_detect #(
   parameter logic [7:0] COMMA = phy_defs::COMMA
) (
   input  logic [7:0] i_sr,
   input  logic [2:0] i_bit_cnt,
   output logic       o_is_comma,
   output logic       o_boundary
);

   assign o_is_comma = (i_sr == COMMA);

   // The counter wraps 7 -> 0, so a zero count marks the edge that follows
   // the last bit of an aligned symbol.
   assign o_boundary = (i_bit_cnt == 3'd0);

endmodule
`default_nettype wire

// File: rtl/serial_parallel_rx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_parallel_rx
//  Description : One-lane receive deserializer. Shifts the serial stream in
//                MSB first, hunts for the comma symbol to find the byte
//                boundary, declares the link active after LOCK_COUNT aligned
//                commas and then delivers one byte every 8 bit clocks.
//                Idle commas are delivered with valid_out low.
//  Parameters  : COMMA       - alignment / idle symbol
//                LOCK_COUNT  - aligned commas needed to go active (2..15)
//  Ports       : clk32f      - serial bit clock (rising edge)
//                reset       - asynchronous active-low reset
//                in          - serial data, MSB first
//                out         - last delivered byte
//                valid_out   - out holds a non-comma byte
//                byte_strobe - one-cycle pulse when out/valid_out update
//                active      - link aligned and active
//  Revision    : 1.0  initial release
// ============================================================================
module serial_parallel_rx #(
   parameter logic [7:0] COMMA      = phy_defs::COMMA,
   parameter int         LOCK_COUNT = 4
) (
   input  logic       clk32f,
   input  logic       reset,
   input  logic       in,
   output logic [7:0] out,
   output logic       valid_out,
   output logic       byte_strobe,
   output logic       active
);

   import phy_defs::*;

   localparam logic [3:0] c_lock_count = 4'(LOCK_COUNT);

   logic [7:0] r_sr;
   logic [2:0] r_bit_cnt;
   logic [3:0] r_comma_cnt;
   rx_state_t  r_state;

   logic       w_is_comma;
   logic       w_boundary;
   logic [3:0] w_comma_next;

   // ------------------------------------------------------------------
   // Serial shift register: runs on every edge regardless of state so the
   // hunt always sees the most recent 8 bits.
   // ------------------------------------------------------------------
   always_ff @(posedge clk32f or negedge reset) begin
      if (!reset) begin
         r_sr <= 8'h00;
      end else begin
         r_sr <= {r_sr[6:0], in};
      end
   end

   comma_detect #(
      .COMMA      (COMMA)
   ) u_comma_detect (
      .i_sr       (r_sr),
      .i_bit_cnt  (r_bit_cnt),
      .o_is_comma (w_is_comma),
      .o_boundary (w_boundary)
   );

   assign w_comma_next = sat_inc4(r_comma_cnt);

   // ------------------------------------------------------------------
   // Alignment FSM with registered outputs. Decisions look at r_sr as it
   // stood before this edge, so a byte whose last bit lands on edge E is
   // acted on at edge E+1.
   // ------------------------------------------------------------------
   always_ff @(posedge clk32f or negedge reset) begin
      if (!reset) begin
         r_state     <= HUNT;
         r_bit_cnt   <= 3'd0;
         r_comma_cnt <= 4'd0;
         out         <= 8'h00;
         valid_out   <= 1'b0;
         byte_strobe <= 1'b0;
         active      <= 1'b0;
      end else begin
         // The bit counter free-runs; it only carries meaning once a comma
         // detection in HUNT has fixed its phase.
         r_bit_cnt   <= r_bit_cnt + 3'd1;
         byte_strobe <= 1'b0;

         case (r_state)
            HUNT: begin
               if (w_is_comma) begin
                  // The comma just seen ended one edge ago, so the next
                  // boundary is 8 edges away: start the count at 1.
                  r_bit_cnt   <= 3'd1;
                  r_comma_cnt <= 4'd1;
                  r_state     <= ALIGN;
               end
            end

            ALIGN: begin
               if (w_boundary) begin
                  if (w_is_comma) begin
                     r_comma_cnt <= w_comma_next;
                     if (w_comma_next == c_lock_count) begin
                        r_state <= ACTIVE;
                        active  <= 1'b1;
                     end
                  end else begin
                     r_comma_cnt <= 4'd0;
                     r_state     <= HUNT;
                  end
               end
            end

            ACTIVE: begin
               // Lock is never dropped here; only reset leaves ACTIVE.
               if (w_boundary) begin
                  out         <= r_sr;
                  valid_out   <= !w_is_comma;
                  byte_strobe <= 1'b1;
               end
            end

            default: begin
               r_state <= HUNT;
               active  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
